pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Consumer side of the next-PC datapath. Holds the architectural program counter and loads the core-computed NextPC.
- Fetches the instruction at the current PC from instruction memory over a valid/ready request channel and a valid response channel.
- Holds the fetched instruction stable until the core signals Advance.
- Detects misaligned targets and instruction-memory timeouts, and reports them as a sticky fault.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles spent in WAIT before a timeout fault; legal range 1 to 65535.
- INSTR_W, 32, instruction width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- NextPC  in  64  next PC from the branch/increment logic; sampled only on an accepted Advance.
- Advance  in  1  core has consumed Instruction; load NextPC.
- CurrentPC  out  64  registered architectural PC.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  64  fetch address; always equals CurrentPC.
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  response data valid.
- imem_resp_data  in  INSTR_W  fetched instruction.
- Instruction  out  INSTR_W  registered instruction.
- InstrValid  out  1  Instruction is valid for CurrentPC.
- FaultCode  out  2  00 none, 01 misaligned NextPC, 10 imem timeout; sticky.
- FetchCount  out  32  number of completed fetches; wraps at 2^32.

Behaviour:
- Reset (synchronous, active-high; dominates every other input in the same cycle):
  - state = IDLE, CurrentPC = RESET_PC, Instruction = 0.
  - InstrValid = 0, FaultCode = 00, FetchCount = 0, timeout counter = 0.
  - Reset asserted mid-transaction abandons the outstanding request; a response arriving after reset is ignored because the state is no longer WAIT.
- States and transitions:
  - IDLE: go to REQ unconditionally on the next edge.
  - REQ: imem_req_valid = 1. If imem_req_ready = 1, go to WAIT and clear the timeout counter; otherwise stay in REQ. imem_req_addr must stay stable while valid and not ready.
  - WAIT: imem_req_valid = 0.
    - If imem_resp_valid = 1: Instruction <= imem_resp_data, FetchCount += 1, go to HOLD.
    - Else, if the counter equals TIMEOUT-1: FaultCode <= 10, go to FAULT.
    - Else increment the counter.
    - A response on the same cycle the counter reaches TIMEOUT-1 wins; no fault is raised.
  - HOLD: InstrValid = 1. On Advance = 1:
    - If NextPC[1:0] == 00: CurrentPC <= NextPC, go to REQ.
    - If NextPC[1:0] != 00: CurrentPC is unchanged, FaultCode <= 01, go to FAULT.
  - FAULT: terminal until Reset. imem_req_valid = 0, InstrValid = 0, Advance ignored.
- InstrValid and imem_req_valid are decoded from the state register, with no combinational path from any input.
- Latency:
  - A response in cycle N makes InstrValid = 1 and Instruction updated in cycle N+1.
  - Advance in cycle N makes CurrentPC = NextPC and imem_req_valid = 1 in cycle N+1.
  - Minimum fetch period with zero-wait memory and Advance held high is 3 cycles (REQ, WAIT, HOLD).
- Ignored inputs:
  - Advance outside HOLD.
  - imem_resp_valid outside WAIT.
  - imem_req_ready outside REQ.
- FetchCount wraps from FFFF_FFFF to 0 without flagging.
- NextPC equal to CurrentPC (self-loop) is legal and refetches.

Decomposition:
- Shared package/include holds:
  - state encoding constants: IDLE = 0, REQ = 1, WAIT = 2, HOLD = 3, FAULT = 4 (3 bits).
  - FaultCode constants: FAULT_NONE, FAULT_MISALIGN, FAULT_TIMEOUT.
  - The 64-bit address width constant, shared with the next-PC logic.
- One natural sub-module: fetch_timeout_ctr, a loadable up-counter with terminal-count flag parameterised by TIMEOUT.
- The FSM and PC register stay in the top module.

Test Plan:
- Reset with RESET_PC = 64'h100, memory always ready, response one cycle after accept with data 32'hF84003E9 -> REQ addr 64'h100 two cycles after reset release; InstrValid = 1 with Instruction = F84003E9; FetchCount = 1.
- In HOLD, Advance with NextPC = 64'h104, then again with NextPC = 64'h0F0 (branch back) -> CurrentPC sequence 100, 104, 0F0; imem_req_addr matches each; FetchCount = 3.
- imem_req_ready held low for 5 cycles -> imem_req_valid and addr stable for all 5 cycles; the request is accepted on the 6th; no fault.
- TIMEOUT = 4 with no response -> FaultCode = 10 after 4 WAIT cycles; InstrValid stays 0; subsequent Advance and resp_valid are ignored; Reset clears to 00.
- Advance with NextPC = 64'h106 -> FaultCode = 01, CurrentPC stays at its old value, no further requests.
- Reset asserted in WAIT, with a response arriving the following cycle -> response ignored; Instruction = 0; FetchCount = 0; a new request issues to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC fetch path: FSM encoding, fault codes, address width.
// The next-PC logic imports the same package so the two sides agree on ADDR_W.
package pc_fetch_unit_pkg;

    localparam int ADDR_W = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and imem.
interface pc_fetch_unit_if
    import pc_fetch_unit_pkg::*;
#(
    parameter int INSTR_W = 32
);
    logic                imem_req_valid;
    logic [ADDR_W-1:0]   imem_req_addr;
    logic                imem_req_ready;
    logic                imem_resp_valid;
    logic [INSTR_W-1:0]  imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_timeout_ctr.sv
// Loadable up-counter for the WAIT state; o_tc flags the TIMEOUT-1 terminal count.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at the terminal count so a stray enable cannot wrap it.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register plus the fetch FSM: request, wait, hold until Advance.
// Misaligned targets and memory timeouts park the unit in FAULT until Reset.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                TIMEOUT  = 16,
    parameter int                INSTR_W  = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [ADDR_W-1:0]   NextPC,
    input  logic                Advance,
    output logic [ADDR_W-1:0]   CurrentPC,
    pc_fetch_unit_if.master     imem,
    output logic [INSTR_W-1:0]  Instruction,
    output logic                InstrValid,
    output logic [1:0]          FaultCode,
    output logic [31:0]         FetchCount
);
    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_instr;
    logic [1:0]          r_fault;
    logic [31:0]         r_fetch_cnt;

    logic w_accept;
    logic w_resp;
    logic w_adv;
    logic w_tc;
    logic w_ctr_en;

    // Qualify every input with the state that is allowed to observe it.
    assign w_accept = (r_state == ST_REQ)  && imem.imem_req_ready;
    assign w_resp   = (r_state == ST_WAIT) && imem.imem_resp_valid;
    assign w_adv    = (r_state == ST_HOLD) && Advance;
    assign w_ctr_en = (r_state == ST_WAIT) && !imem.imem_resp_valid;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk (CLK),
        .i_rst (Reset),
        .i_clr (w_accept),
        .i_en  (w_ctr_en),
        .o_tc  (w_tc)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_fault     <= FAULT_NONE;
            r_fetch_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_accept) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A response in the terminal-count cycle still wins.
                    if (w_resp) begin
                        r_instr     <= imem.imem_resp_data;
                        r_fetch_cnt <= r_fetch_cnt + 32'd1;
                        r_state     <= ST_HOLD;
                    end else if (w_tc) begin
                        r_fault <= FAULT_TIMEOUT;
                        r_state <= ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (w_adv) begin
                        if (is_aligned(NextPC)) begin
                            r_pc    <= NextPC;
                            r_state <= ST_REQ;
                        end else begin
                            r_fault <= FAULT_MISALIGN;
                            r_state <= ST_FAULT;
                        end
                    end
                end
                ST_FAULT: r_state <= ST_FAULT;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output path.
    assign imem.imem_req_valid = (r_state == ST_REQ);
    assign imem.imem_req_addr  = r_pc;
    assign InstrValid          = (r_state == ST_HOLD);
    assign CurrentPC           = r_pc;
    assign Instruction         = r_instr;
    assign FaultCode           = r_fault;
    assign FetchCount          = r_fetch_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a transaction-level model (PC, fetch count,
// last instruction, fault) predicts outputs while the bench plays the memory.
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [63:0] RST_PC = 64'h100;
    localparam int          TMO    = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] NextPC;
    logic        Advance;
    logic [63:0] CurrentPC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [1:0]  FaultCode;
    logic [31:0] FetchCount;

    pc_fetch_unit_if #(.INSTR_W(32)) ifc ();

    pc_fetch_unit #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO),
        .INSTR_W  (32)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .NextPC      (NextPC),
        .Advance     (Advance),
        .CurrentPC   (CurrentPC),
        .imem        (ifc),
        .Instruction (Instruction),
        .InstrValid  (InstrValid),
        .FaultCode   (FaultCode),
        .FetchCount  (FetchCount)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Random activity on inputs the current state must ignore.
    task automatic noise();
        ifc.imem_resp_valid = 1'($urandom_range(0, 1));
        ifc.imem_resp_data  = $urandom;
        Advance             = 1'($urandom_range(0, 1));
        NextPC              = {$urandom, $urandom};
    endtask

    task automatic quiet();
        ifc.imem_req_ready  = 1'b0;
        ifc.imem_resp_valid = 1'b0;
        Advance             = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        m_pc  = RST_PC;
        m_cnt = '0;
        m_instr = '0;
        chk("rst_pc",    CurrentPC, RST_PC);
        chk("rst_instr", Instruction, 0);
        chk("rst_ivld",  InstrValid, 0);
        chk("rst_fault", FaultCode, FAULT_NONE);
        chk("rst_fcnt",  FetchCount, 0);
        chk("rst_rqv",   ifc.imem_req_valid, 0);
        tick();
        chk("post_rst_rqv",  ifc.imem_req_valid, 1);
        chk("post_rst_addr", ifc.imem_req_addr, RST_PC);
    endtask

    // Starts in REQ: stall the request, accept it, answer after lat WAIT cycles.
    task automatic fetch(input int stall, input int lat, input logic [31:0] data);
        chk("req_valid", ifc.imem_req_valid, 1);
        chk("req_addr",  ifc.imem_req_addr, m_pc);
        chk("cur_pc",    CurrentPC, m_pc);
        for (int i = 0; i < stall; i++) begin
            ifc.imem_req_ready = 1'b0;
            noise();
            tick();
            chk("stall_rqv",  ifc.imem_req_valid, 1);
            chk("stall_addr", ifc.imem_req_addr, m_pc);
        end
        ifc.imem_req_ready = 1'b1;
        noise();
        tick();
        chk("wait_rqv", ifc.imem_req_valid, 0);
        for (int i = 0; i < lat; i++) begin
            chk("wait_ivld",  InstrValid, 0);
            chk("wait_fault", FaultCode, FAULT_NONE);
            ifc.imem_resp_valid = 1'b0;
            ifc.imem_resp_data  = $urandom;
            ifc.imem_req_ready  = 1'($urandom_range(0, 1));
            Advance             = 1'($urandom_range(0, 1));
            NextPC              = {$urandom, $urandom};
            tick();
        end
        ifc.imem_resp_valid = 1'b1;
        ifc.imem_resp_data  = data;
        Advance             = 1'b0;
        tick();
        quiet();
        m_cnt   = m_cnt + 32'd1;
        m_instr = data;
        chk("resp_ivld",  InstrValid, 1);
        chk("resp_instr", Instruction, data);
        chk("resp_fcnt",  FetchCount, m_cnt);
        chk("resp_fault", FaultCode, FAULT_NONE);
        chk("resp_rqv",   ifc.imem_req_valid, 0);
    endtask

    // Starts in HOLD: idle for delay cycles, then Advance to npc.
    task automatic advance(input logic [63:0] npc, input int delay);
        for (int i = 0; i < delay; i++) begin
            ifc.imem_resp_valid = 1'($urandom_range(0, 1));
            ifc.imem_resp_data  = $urandom;
            ifc.imem_req_ready  = 1'($urandom_range(0, 1));
            Advance             = 1'b0;
            tick();
            chk("hold_ivld",  InstrValid, 1);
            chk("hold_instr", Instruction, m_instr);
            chk("hold_rqv",   ifc.imem_req_valid, 0);
        end
        quiet();
        Advance = 1'b1;
        NextPC  = npc;
        tick();
        Advance = 1'b0;
        if (npc[1:0] == 2'b00) begin
            m_pc = npc;
            chk("adv_pc",    CurrentPC, npc);
            chk("adv_rqv",   ifc.imem_req_valid, 1);
            chk("adv_addr",  ifc.imem_req_addr, npc);
            chk("adv_ivld",  InstrValid, 0);
        end else begin
            chk("mis_fault", FaultCode, FAULT_MISALIGN);
            chk("mis_pc",    CurrentPC, m_pc);
            for (int i = 0; i < 4; i++) begin
                chk("mis_rqv",  ifc.imem_req_valid, 0);
                chk("mis_ivld", InstrValid, 0);
                ifc.imem_req_ready = 1'b1;
                noise();
                NextPC = {$urandom, $urandom} & ~64'h3;
                tick();
                chk("mis_hold_fault", FaultCode, FAULT_MISALIGN);
                chk("mis_hold_pc",    CurrentPC, m_pc);
                chk("mis_hold_fcnt",  FetchCount, m_cnt);
            end
            quiet();
        end
    endtask

    function automatic logic [63:0] pick_npc(input logic [63:0] pc);
        case ($urandom_range(0, 3))
            0:       return pc;
            1:       return pc + 64'd4;
            default: return {$urandom, $urandom} & ~64'h3;
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        NextPC = '0;
        ifc.imem_resp_data = '0;
        quiet();

        // Directed opening sequence.
        do_reset();
        fetch(0, 0, 32'hF84003E9);
        advance(64'h104, 0);
        fetch(5, 0, $urandom);
        advance(64'h0F0, 1);
        fetch(0, TMO - 1, $urandom);
        chk("dir_pc",   CurrentPC, 64'h0F0);
        chk("dir_fcnt", FetchCount, 3);

        // Random fetch/advance traffic.
        for (int it = 0; it < 30; it++) begin
            advance(pick_npc(m_pc), $urandom_range(0, 2));
            fetch($urandom_range(0, 3), $urandom_range(0, TMO - 1), $urandom);
        end

        // Misaligned target.
        advance(m_pc + 64'd6, 0);

        // Memory timeout.
        do_reset();
        ifc.imem_req_ready = 1'b1;
        tick();
        quiet();
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_pre_fault", FaultCode, FAULT_NONE);
            chk("tmo_pre_ivld",  InstrValid, 0);
            tick();
        end
        chk("tmo_fault", FaultCode, FAULT_TIMEOUT);
        for (int i = 0; i < 5; i++) begin
            ifc.imem_req_ready  = 1'b1;
            ifc.imem_resp_valid = 1'b1;
            ifc.imem_resp_data  = $urandom;
            Advance             = 1'b1;
            NextPC              = {$urandom, $urandom} & ~64'h3;
            tick();
            chk("tmo_hold_fault", FaultCode, FAULT_TIMEOUT);
            chk("tmo_hold_ivld",  InstrValid, 0);
            chk("tmo_hold_rqv",   ifc.imem_req_valid, 0);
            chk("tmo_hold_fcnt",  FetchCount, 0);
            chk("tmo_hold_pc",    CurrentPC, RST_PC);
        end

        // Reset while a request is outstanding; the late response must be dropped.
        do_reset();
        fetch(1, 1, 32'h12345678);
        advance(64'h200, 0);
        ifc.imem_req_ready = 1'b1;
        tick();
        quiet();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        ifc.imem_resp_valid = 1'b1;
        ifc.imem_resp_data  = 32'hDEADBEEF;
        tick();
        quiet();
        chk("late_instr", Instruction, 0);
        chk("late_fcnt",  FetchCount, 0);
        chk("late_ivld",  InstrValid, 0);
        chk("late_rqv",   ifc.imem_req_valid, 1);
        chk("late_addr",  ifc.imem_req_addr, RST_PC);
        m_pc = RST_PC;
        m_cnt = '0;
        fetch(0, 2, 32'hCAFEF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
